// File: rtl/codec_cfg_pkg.sv
// codec_cfg_pkg
//   Shared configuration for the audio codec power-up sequencer:
//   - codec_reg_t        : one I2C register write (register address byte + data byte)
//   - INIT_LEN           : number of entries in the power-up table
//   - CODEC_INIT_TABLE   : constant register table, written in index order
//   - codec_init_state_e : sequencer FSM state encoding
//   Register address bytes follow the WM8731 layout: {reg[6:0], data[8]}.
package codec_cfg_pkg;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } codec_reg_t;

  localparam int unsigned INIT_LEN = 10;

  localparam codec_reg_t CODEC_INIT_TABLE [INIT_LEN] = '{
    '{8'h1E, 8'h00},  // R15 reset
    '{8'h0C, 8'h00},  // R6  power down control: everything on
    '{8'h00, 8'h17},  // R0  left line in
    '{8'h02, 8'h17},  // R1  right line in
    '{8'h04, 8'h79},  // R2  left headphone out
    '{8'h06, 8'h79},  // R3  right headphone out
    '{8'h08, 8'h12},  // R4  analog audio path
    '{8'h0A, 8'h00},  // R5  digital audio path
    '{8'h0E, 8'h42},  // R7  digital interface format
    '{8'h12, 8'h01}   // R9  active
  };

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } codec_init_state_e;

endpackage

// File: rtl/codec_init_seq.sv
// codec_init_seq
//   Power-up configuration sequencer for the audio codec. Waits a power-up
//   delay, then writes every CODEC_INIT_TABLE entry through i2c_controller's
//   start/busy/ack_error handshake, retrying NACKed entries up to MAX_RETRY
//   times. init_done / init_error report the outcome.
//
//   Optional feature (compile-time macro): CODEC_INIT_TIMEOUT_EN
//     defined   : watchdog of TIMEOUT_CYCLES in WAIT_BUSY and WAIT_DONE;
//                 expiry counts as an ack error.
//     undefined : both wait states wait indefinitely.
//
//   Ports
//     clk, rst_n      : system clock, asynchronous active-low reset
//     restart         : pulse, reruns the table from DONE or ERROR only
//     i2c_start       : one-cycle start pulse to the controller
//     i2c_dev_addr    : constant DEV_ADDR
//     i2c_reg_addr    : register address of the current entry
//     i2c_data        : data byte of the current entry
//     i2c_busy        : controller busy
//     i2c_ack_error   : controller NACK flag, valid when busy falls
//     init_done       : level, whole table written
//     init_error      : level, an entry exhausted its retries
//     cur_index       : current table index (debug)
module codec_init_seq
  import codec_cfg_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR       = 7'h34,
  parameter int unsigned POWERUP_CYCLES = 50_000,
  parameter int unsigned GAP_CYCLES     = 500,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 200_000,
  parameter int unsigned IDX_W          = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  output logic             i2c_start,
  output logic [6:0]       i2c_dev_addr,
  output logic [7:0]       i2c_reg_addr,
  output logic [7:0]       i2c_data,
  input  logic             i2c_busy,
  input  logic             i2c_ack_error,
  output logic             init_done,
  output logic             init_error,
  output logic [IDX_W-1:0] cur_index
);

`ifdef CODEC_INIT_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // The watchdog limit only sizes the counter when the watchdog exists.
  localparam int unsigned TMO_SIZE = TIMEOUT_EN ? TIMEOUT_CYCLES : 0;
  localparam int unsigned CNT_MAX_A = (POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > TMO_SIZE) ? CNT_MAX_A : TMO_SIZE;
  localparam int unsigned CNT_W     = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(INIT_LEN - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

  codec_init_state_e  state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [RETRY_W-1:0] retry_q;
  logic               fatal_q;    // current entry used up its retries
  logic               wrapped_q;  // last entry written successfully
  logic [IDX_W-1:0]   idx_next;
  logic               timeout_hit;
  logic               txn_end;
  logic               txn_fail;

  assign i2c_dev_addr = DEV_ADDR;
  assign idx_next     = cur_index + 1'b1;

  // Transaction outcome: busy falling (ack_error sampled) or watchdog expiry.
  always_comb begin
    timeout_hit = 1'b0;
`ifdef CODEC_INIT_TIMEOUT_EN
    timeout_hit = (cnt_q == '0);
`endif
    txn_end  = 1'b0;
    txn_fail = 1'b0;
    case (state_q)
      ST_WAIT_BUSY: begin
        if (!i2c_busy && timeout_hit) begin
          txn_end  = 1'b1;
          txn_fail = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!i2c_busy) begin
          txn_end  = 1'b1;
          txn_fail = i2c_ack_error;
        end else if (timeout_hit) begin
          txn_end  = 1'b1;
          txn_fail = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_POWERUP;
      cnt_q        <= CNT_W'(POWERUP_CYCLES);
      retry_q      <= '0;
      fatal_q      <= 1'b0;
      wrapped_q    <= 1'b0;
      cur_index    <= '0;
      i2c_start    <= 1'b0;
      i2c_reg_addr <= CODEC_INIT_TABLE[0].reg_addr;
      i2c_data     <= CODEC_INIT_TABLE[0].data;
      init_done    <= 1'b0;
      init_error   <= 1'b0;
    end else begin
      i2c_start <= 1'b0;

      case (state_q)
        ST_POWERUP: begin
          if (cnt_q == '0) state_q <= ST_ISSUE;
          else             cnt_q   <= cnt_q - 1'b1;
        end

        ST_ISSUE: begin
          if (!i2c_busy) begin
            i2c_start <= 1'b1;
            state_q   <= ST_WAIT_BUSY;
`ifdef CODEC_INIT_TIMEOUT_EN
            cnt_q     <= CNT_W'(TIMEOUT_CYCLES);
`endif
          end
        end

        // Both wait states share the outcome handling; only WAIT_BUSY
        // advances on busy rising.
        ST_WAIT_BUSY, ST_WAIT_DONE: begin
          if (txn_end) begin
            cnt_q   <= CNT_W'(GAP_CYCLES);
            state_q <= ST_GAP;
            if (txn_fail) begin
              if (retry_q < RETRY_LIM) retry_q <= retry_q + 1'b1;
              else                     fatal_q <= 1'b1;
            end else begin
              retry_q <= '0;
              if (cur_index == LAST_IDX) begin
                cur_index    <= '0;
                wrapped_q    <= 1'b1;
                i2c_reg_addr <= CODEC_INIT_TABLE[0].reg_addr;
                i2c_data     <= CODEC_INIT_TABLE[0].data;
              end else begin
                cur_index    <= idx_next;
                i2c_reg_addr <= CODEC_INIT_TABLE[idx_next].reg_addr;
                i2c_data     <= CODEC_INIT_TABLE[idx_next].data;
              end
            end
          end else if (state_q == ST_WAIT_BUSY && i2c_busy) begin
            state_q <= ST_WAIT_DONE;
`ifdef CODEC_INIT_TIMEOUT_EN
            cnt_q   <= CNT_W'(TIMEOUT_CYCLES);
`endif
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_GAP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (fatal_q) begin
            state_q    <= ST_ERROR;
            init_error <= 1'b1;
          end else if (wrapped_q) begin
            state_q   <= ST_DONE;
            init_done <= 1'b1;
          end else begin
            state_q <= ST_ISSUE;
          end
        end

        ST_DONE, ST_ERROR: begin
          if (restart) begin
            state_q      <= ST_ISSUE;
            cur_index    <= '0;
            retry_q      <= '0;
            fatal_q      <= 1'b0;
            wrapped_q    <= 1'b0;
            init_done    <= 1'b0;
            init_error   <= 1'b0;
            i2c_reg_addr <= CODEC_INIT_TABLE[0].reg_addr;
            i2c_data     <= CODEC_INIT_TABLE[0].data;
          end
        end

        default: state_q <= ST_POWERUP;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_init_seq.sv
module tb_codec_init_seq;

  localparam int P        = 10;
  localparam int G        = 2;
  localparam int MR       = 3;
  localparam int T        = 50;
  localparam int BUSY_LEN = 5;
  localparam int N        = 10;

  // Expected table, written out independently: {reg_addr, data}
  logic [15:0] exp_tab [N] = '{16'h1E00, 16'h0C00, 16'h0017, 16'h0217, 16'h0479,
                               16'h0679, 16'h0812, 16'h0A00, 16'h0E42, 16'h1201};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       restart = 1'b0;
  logic       force_busy = 1'b0;
  logic       bfm_busy = 1'b0;
  logic       ack_err = 1'b0;
  logic       i2c_busy;
  logic       i2c_start;
  logic [6:0] i2c_dev_addr;
  logic [7:0] i2c_reg_addr;
  logic [7:0] i2c_data;
  logic       init_done;
  logic       init_error;
  logic [3:0] cur_index;

  assign i2c_busy = force_busy | bfm_busy;

  codec_init_seq #(
    .DEV_ADDR       (7'h34),
    .POWERUP_CYCLES (P),
    .GAP_CYCLES     (G),
    .MAX_RETRY      (MR),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .restart       (restart),
    .i2c_start     (i2c_start),
    .i2c_dev_addr  (i2c_dev_addr),
    .i2c_reg_addr  (i2c_reg_addr),
    .i2c_data      (i2c_data),
    .i2c_busy      (i2c_busy),
    .i2c_ack_error (ack_err),
    .init_done     (init_done),
    .init_error    (init_error),
    .cur_index     (cur_index)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // cycle index: 0 on the first rising edge with rst_n high
  int cyc = -1;
  initial forever begin
    @(posedge clk);
    if (rst_n) cyc++;
    else       cyc = -1;
  end

  // start-pulse logger
  int          lg_cyc [$];
  int          lg_idx [$];
  logic [15:0] lg_rd  [$];
  bit          dbl_start  = 1'b0;
  bit          prev_start = 1'b0;
  initial forever begin
    @(negedge clk);
    if (rst_n && i2c_start) begin
      lg_cyc.push_back(cyc);
      lg_idx.push_back(int'(cur_index));
      lg_rd.push_back({i2c_reg_addr, i2c_data});
    end
    if (prev_start && i2c_start) dbl_start = 1'b1;
    prev_start = i2c_start;
  end

  // controller model: busy for BUSY_LEN cycles after a start, optional NACK plan
  int bfm_cnt   = 0;
  int nack_idx  = -1;
  int nack_left = 0;   // >= 100 means NACK forever
  bit silent    = 1'b0;
  bit pend      = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      bfm_busy = 1'b0; ack_err = 1'b0; bfm_cnt = 0;
    end else if (bfm_cnt > 0) begin
      bfm_cnt--;
      if (bfm_cnt == 0) begin
        bfm_busy = 1'b0;
        ack_err  = pend;
      end
    end else if (i2c_start && !silent) begin
      bfm_busy = 1'b1;
      ack_err  = 1'b0;
      bfm_cnt  = BUSY_LEN;
      pend     = 1'b0;
      if (int'(cur_index) == nack_idx && nack_left > 0) begin
        pend = 1'b1;
        if (nack_left < 100) nack_left--;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    lg_cyc.delete(); lg_idx.delete(); lg_rd.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_end(input string name, input int budget);
    int k = 0;
    while (!(init_done || init_error) && k < budget) begin
      @(negedge clk); #1; k++;
    end
    check(name, int'(init_done || init_error), 1);
  endtask

  task automatic wait_pulses(input string name, input int n, input int budget);
    int k = 0;
    while (lg_rd.size() < n && k < budget) begin
      @(negedge clk); #1; k++;
    end
    check(name, int'(lg_rd.size() >= n), 1);
  endtask

  typedef struct {
    int nidx;       // entry that NACKs (-1: none)
    int ntimes;     // how many NACKs (>= 100: forever)
    int exp_pulses;
    int exp_done;
    int exp_err;
    int exp_idx;
  } vec_t;

  vec_t vecs [6];
  int   exp_i [$];

  initial begin
    vecs[0] = '{-1,    0, 10, 1, 0, 0};  // clean run
    vecs[1] = '{ 2,    1, 11, 1, 0, 0};  // entry 2 NACKs once
    vecs[2] = '{ 0, 1000,  4, 0, 1, 0};  // entry 0 always NACKs
    vecs[3] = '{ 9,    2, 12, 1, 0, 0};  // last entry NACKs twice
    vecs[4] = '{ 5,    3, 13, 1, 0, 0};  // exactly MAX_RETRY NACKs still succeeds
    vecs[5] = '{ 5,    4,  9, 0, 1, 5};  // one NACK too many

    // reset state
    rst_n = 1'b0;
    #12;
    check("rst_start", int'(i2c_start), 0);
    check("rst_idx", int'(cur_index), 0);
    check("rst_entry0", int'({i2c_reg_addr, i2c_data}), int'(exp_tab[0]));
    check("rst_done", int'(init_done), 0);
    check("rst_error", int'(init_error), 0);
    check("dev_addr", int'(i2c_dev_addr), 'h34);

    for (int v = 0; v < 6; v++) begin
      int mfail;
      int cmp_n;
      nack_idx  = vecs[v].nidx;
      nack_left = vecs[v].ntimes;
      silent    = 1'b0;
      do_reset();
      wait_end($sformatf("v%0d_end", v), 3000);
      repeat (10) @(negedge clk);
      #1;

      exp_i.delete();
      mfail = 0;
      for (int i = 0; i < N && mfail == 0; i++) begin
        int nk;
        int tries;
        nk    = (i == vecs[v].nidx) ? vecs[v].ntimes : 0;
        tries = (nk > MR) ? MR + 1 : nk + 1;
        for (int r = 0; r < tries; r++) exp_i.push_back(i);
        if (nk > MR) mfail = 1;
      end

      check($sformatf("v%0d_pulses", v), lg_rd.size(), vecs[v].exp_pulses);
      check($sformatf("v%0d_model_pulses", v), lg_rd.size(), exp_i.size());
      check($sformatf("v%0d_done", v), int'(init_done), vecs[v].exp_done);
      check($sformatf("v%0d_error", v), int'(init_error), vecs[v].exp_err);
      check($sformatf("v%0d_idx", v), int'(cur_index), vecs[v].exp_idx);
      if (lg_cyc.size() > 0) check($sformatf("v%0d_first_cyc", v), lg_cyc[0], P + 1);
      else                   check($sformatf("v%0d_first_cyc", v), -1, P + 1);
      cmp_n = (lg_rd.size() < exp_i.size()) ? lg_rd.size() : exp_i.size();
      for (int k = 0; k < cmp_n; k++) begin
        check($sformatf("v%0d_p%0d_idx", v, k), lg_idx[k], exp_i[k]);
        check($sformatf("v%0d_p%0d_regdata", v, k), int'(lg_rd[k]), int'(exp_tab[exp_i[k]]));
      end
    end
    nack_idx = -1; nack_left = 0;

    // busy already high when ISSUE is reached
    force_busy = 1'b1;
    do_reset();
    while (cyc < 30) @(negedge clk);
    #1;
    check("busy_no_pulse", lg_rd.size(), 0);
    force_busy = 1'b0;
    wait_pulses("busy_pulse_wait", 1, 50);
    if (lg_cyc.size() > 0) check("busy_first_cyc", lg_cyc[0], 31);
    wait_end("busy_end", 3000);
    check("busy_done", int'(init_done), 1);

    // restart outside DONE/ERROR is ignored; restart in DONE reruns without power-up
    do_reset();
    while (cyc < 5) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    wait_pulses("rsi_pulse_wait", 1, 50);
    if (lg_cyc.size() > 0) check("rsi_first_cyc", lg_cyc[0], P + 1);
    wait_end("rsi_end", 3000);
    repeat (5) @(negedge clk);
    begin
      int r;
      int base;
      base = lg_rd.size();
      check("rs_before", base, N);
      r = cyc;
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      #1;
      check("rs_done_cleared", int'(init_done), 0);
      check("rs_idx0", int'(cur_index), 0);
      wait_end("rs_end", 3000);
      repeat (5) @(negedge clk);
      #1;
      check("rs_pulses", lg_rd.size() - base, N);
      if (lg_rd.size() > base) begin
        check("rs_first_cyc", lg_cyc[base], r + 2);
        check("rs_first_idx", lg_idx[base], 0);
        check("rs_first_regdata", int'(lg_rd[base]), int'(exp_tab[0]));
      end
      check("rs_done", int'(init_done), 1);
    end

    // asynchronous reset in WAIT_DONE at entry 3
    do_reset();
    wait_pulses("rw_pulse_wait", 4, 500);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rw_idx", int'(cur_index), 0);
    check("rw_entry0", int'({i2c_reg_addr, i2c_data}), int'(exp_tab[0]));
    check("rw_start", int'(i2c_start), 0);
    check("rw_done", int'(init_done), 0);

    // asynchronous reset while the start pulse is high
    do_reset();
    wait_pulses("rs2_pulse_wait", 2, 500);
    check("rs2_start_high", int'(i2c_start), 1);
    rst_n = 1'b0;
    #1;
    check("rs2_start_drop", int'(i2c_start), 0);
    do_reset();
    wait_pulses("rs2_again_wait", 1, 50);
    if (lg_cyc.size() > 0) check("rs2_again_cyc", lg_cyc[0], P + 1);
    wait_end("rs2_end", 3000);

`ifdef CODEC_INIT_TIMEOUT_EN
    // controller never responds: every attempt times out
    silent = 1'b1;
    do_reset();
    wait_end("tmo_end", 3000);
    repeat (5) @(negedge clk);
    #1;
    check("tmo_pulses", lg_rd.size(), MR + 1);
    check("tmo_error", int'(init_error), 1);
    check("tmo_done", int'(init_done), 0);
    check("tmo_idx", int'(cur_index), 0);
    // WAIT_BUSY holds T+1 cycles, GAP G+1, ISSUE 1
    for (int k = 1; k < lg_cyc.size(); k++)
      check($sformatf("tmo_gap%0d", k), lg_cyc[k] - lg_cyc[k-1], T + G + 3);
    silent = 1'b0;
`endif

    check("no_back_to_back_start", int'(dbl_start), 0);
    check("done_error_exclusive", int'(init_done && init_error), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
